// File: rtl/mem_rd_arbiter_pkg.sv
// Shared definitions for the memory read-bus arbiter: port identifiers,
// arbiter state encodings and the default refill block width.
package mem_rd_arbiter_pkg;

    localparam logic PORT_IC = 1'b0;
    localparam logic PORT_DC = 1'b1;

    localparam logic [0:0] ARB_IDLE = 1'b0;
    localparam logic [0:0] ARB_WAIT = 1'b1;

    localparam int BLK_SIZE_DEFAULT = 128;

endpackage

// File: rtl/mem_rd_arbiter_rd_req_slot.sv
// One-entry pending read request register: captures a cache's ren/addr
// pulse and holds it until the arbiter grants it to memory.
module rd_req_slot
    import mem_rd_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture,
    input  logic              clear,
    input  logic [3:0]        cap_ren,
    input  logic [ADDR_W-1:0] cap_addr,
    output logic              valid,
    output logic [3:0]        ren,
    output logic [ADDR_W-1:0] addr
);

    // Capture only happens into an empty slot and a grant only clears a full one,
    // so the two never coincide; clear is still given priority for safety.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            ren   <= '0;
            addr  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (capture) begin
            valid <= 1'b1;
            ren   <= cap_ren;
            addr  <= cap_addr;
        end
    end

endmodule

// File: rtl/mem_rd_arbiter.sv
// Arbitrates the single main-memory read bus between ICache and DCache refills.
// Default build uses fixed DCache priority; define ARB_RR_EN for round-robin.
module mem_rd_arbiter
    import mem_rd_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int BLK_SIZE = BLK_SIZE_DEFAULT
) (
    input  logic                cpu_clk,
    input  logic                cpu_rst,
    input  logic [3:0]          ic_ren,
    input  logic [ADDR_W-1:0]   ic_raddr,
    output logic                ic_rrdy,
    output logic                ic_rvalid,
    output logic [BLK_SIZE-1:0] ic_rdata,
    input  logic [3:0]          dc_ren,
    input  logic [ADDR_W-1:0]   dc_raddr,
    output logic                dc_rrdy,
    output logic                dc_rvalid,
    output logic [BLK_SIZE-1:0] dc_rdata,
    input  logic                mem_rrdy,
    output logic [3:0]          mem_ren,
    output logic [ADDR_W-1:0]   mem_raddr,
    input  logic                mem_rvalid,
    input  logic [BLK_SIZE-1:0] mem_rdata
);

    logic [0:0]        state;
    logic              owner;
    logic              ic_v, dc_v;
    logic [3:0]        ic_slot_ren, dc_slot_ren;
    logic [ADDR_W-1:0] ic_slot_addr, dc_slot_addr;
    logic              grant;
    logic              winner;
    logic              ic_clear, dc_clear;

`ifdef ARB_RR_EN
    logic last_grant;
`endif

    // A port is busy while its request is queued or while its read is in flight.
    assign ic_rrdy = !ic_v && !((state != ARB_IDLE) && (owner == PORT_IC));
    assign dc_rrdy = !dc_v && !((state != ARB_IDLE) && (owner == PORT_DC));

    rd_req_slot #(.ADDR_W(ADDR_W)) u_ic_slot (
        .clk      (cpu_clk),
        .rst      (cpu_rst),
        .capture  ((ic_ren != 4'd0) && ic_rrdy),
        .clear    (ic_clear),
        .cap_ren  (ic_ren),
        .cap_addr (ic_raddr),
        .valid    (ic_v),
        .ren      (ic_slot_ren),
        .addr     (ic_slot_addr)
    );

    rd_req_slot #(.ADDR_W(ADDR_W)) u_dc_slot (
        .clk      (cpu_clk),
        .rst      (cpu_rst),
        .capture  ((dc_ren != 4'd0) && dc_rrdy),
        .clear    (dc_clear),
        .cap_ren  (dc_ren),
        .cap_addr (dc_raddr),
        .valid    (dc_v),
        .ren      (dc_slot_ren),
        .addr     (dc_slot_addr)
    );

    always_comb begin
        winner = PORT_IC;
        if (ic_v && dc_v) begin
`ifdef ARB_RR_EN
            winner = (last_grant == PORT_DC) ? PORT_IC : PORT_DC;
`else
            winner = PORT_DC;
`endif
        end else if (dc_v) begin
            winner = PORT_DC;
        end
    end

    assign grant    = (state == ARB_IDLE) && mem_rrdy && (ic_v || dc_v);
    assign ic_clear = grant && (winner == PORT_IC);
    assign dc_clear = grant && (winner == PORT_DC);

    // IDLE issues one registered read pulse per grant; WAIT holds the address
    // until the block returns, leaving a mandatory dead IDLE cycle between reads.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state     <= ARB_IDLE;
            owner     <= PORT_IC;
            mem_ren   <= 4'd0;
            mem_raddr <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (grant) begin
                        mem_ren   <= (winner == PORT_DC) ? dc_slot_ren : ic_slot_ren;
                        mem_raddr <= (winner == PORT_DC) ? dc_slot_addr : ic_slot_addr;
                        owner     <= winner;
                        state     <= ARB_WAIT;
                    end else begin
                        mem_ren <= 4'd0;
                    end
                end
                default: begin
                    mem_ren <= 4'd0;
                    if (mem_rvalid) begin
                        state <= ARB_IDLE;
                    end
                end
            endcase
        end
    end

`ifdef ARB_RR_EN
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            last_grant <= PORT_DC;
        end else if (grant) begin
            last_grant <= winner;
        end
    end
`endif

    // Data fans out to both caches; only the owner's rvalid qualifies it.
    assign ic_rvalid = (state == ARB_WAIT) && mem_rvalid && (owner == PORT_IC);
    assign dc_rvalid = (state == ARB_WAIT) && mem_rvalid && (owner == PORT_DC);
    assign ic_rdata  = mem_rdata;
    assign dc_rdata  = mem_rdata;

endmodule

// File: doc/mem_rd_arbiter.md
Name: mem_rd_arbiter

Overview:
- Shares the single main-memory read bus between the ICache refill port and the DCache refill port.
- Each cache sees a private bus with the same protocol it expects from memory: `rrdy`, a one-cycle `ren` pulse, `raddr`, `rvalid` and a 128-bit `rdata` block.
- Holds one pending request per port, issues one memory read at a time, and routes the returned block to the port that owns it.
- Sits between ICache/DCache and the memory read-bus slave.

Parameters:
- ADDR_W, 32, address width.
- BLK_SIZE, 128, refill block width in bits (4 words).

Ports:
- cpu_clk  input  1  clock.
- cpu_rst  input  1  reset, asynchronous, active-high.
- ic_ren  input  4  ICache read enable pulse (non-zero = request).
- ic_raddr  input  ADDR_W  ICache block address.
- ic_rrdy  output  1  ICache port may pulse ic_ren.
- ic_rvalid  output  1  block for ICache valid this cycle.
- ic_rdata  output  BLK_SIZE  block data to ICache.
- dc_ren  input  4  DCache read enable pulse.
- dc_raddr  input  ADDR_W  DCache block address.
- dc_rrdy  output  1  DCache port may pulse dc_ren.
- dc_rvalid  output  1  block for DCache valid this cycle.
- dc_rdata  output  BLK_SIZE  block data to DCache.
- mem_rrdy  input  1  memory can accept a read.
- mem_ren  output  4  memory read enable, one-cycle pulse.
- mem_raddr  output  ADDR_W  memory read address.
- mem_rvalid  input  1  memory read data valid.
- mem_rdata  input  BLK_SIZE  memory read data.

Behaviour:
- One clock (cpu_clk). Reset cpu_rst is asynchronous and active-high.
- Reset values:
  - state=IDLE.
  - Both pending slots empty; owner=IC.
  - mem_ren=0, mem_raddr=0, ic_rvalid=dc_rvalid=0.
  - ic_rrdy=dc_rrdy=1 after reset releases.
- Per port, a pending slot holds {v, ren, addr}.
  - A port's ren is captured into its slot at the clock edge when ren!=0 and that port's rrdy=1.
  - ren!=0 while rrdy=0 is a protocol violation and is ignored.
- xx_rrdy (combinational) = slot empty AND NOT (state!=IDLE AND owner==xx).
  - So each port has at most one request in flight or queued.
- State machine IDLE / WAIT:
  - IDLE:
    - If mem_rrdy=1 and at least one slot is valid, select a winner.
    - Register mem_ren<=slot.ren and mem_raddr<=slot.addr, set owner<=winner, clear the winner's slot, go to WAIT.
    - Otherwise mem_ren<=0.
  - WAIT:
    - mem_ren<=0 (so mem_ren is exactly one cycle).
    - mem_raddr holds its value.
    - On mem_rvalid=1, go to IDLE.
- Latency: a ren pulse in cycle c gives mem_ren high in cycle c+2 if the bus is idle and mem_rrdy=1.
- Return path is combinational:
  - ic_rvalid = (state==WAIT) & mem_rvalid & (owner==IC).
  - dc_rvalid is the same with owner==DC.
  - ic_rdata = dc_rdata = mem_rdata (fan-out; consumers qualify with their own rvalid).
- mem_rvalid in IDLE is dropped, not forwarded.
- Default arbitration is fixed priority: DCache wins when both slots are valid.
- Simultaneous events:
  - A new pulse from port X in the same cycle that X's previous block returns is not possible, because rrdy is low until the return cycle ends.
  - The other port may enqueue at any time while its slot is empty.
- Back-to-back reads: the IDLE cycle between two transactions is mandatory (one dead cycle).
- Reset mid-transaction:
  - Slots and the outstanding owner are discarded.
  - A late mem_rvalid after reset is dropped (state is IDLE).

Optional Feature:
- Macro ARB_RR_EN.
- Defined:
  - Round-robin arbitration using a last_grant register, reset value DC.
  - On a tie, the port not granted last wins. The first tie after reset goes to ICache.
  - last_grant updates at each grant.
- Undefined: fixed priority, DCache over ICache. No last_grant register.

Decomposition:
- Shared package holds:
  - port-id constants PORT_IC=0, PORT_DC=1;
  - state encodings ARB_IDLE and ARB_WAIT;
  - BLK_SIZE default of 128.
- One natural sub-module: rd_req_slot.
  - A one-entry request holding register with capture, clear, valid and addr/ren outputs.
  - Instantiated once per port.

Test Plan:
- Single ICache read:
  - Stimulus: ic_ren=F, ic_raddr=0x0000_1230 in cycle 0; mem_rrdy=1; mem_rvalid returns 3 cycles after mem_ren with mem_rdata=0xA..A.
  - Response: mem_ren=F and mem_raddr=0x1230 in cycle 2 only; ic_rvalid=1 and dc_rvalid=0 in the return cycle; ic_rrdy=0 from cycle 1 until the return.
- Simultaneous requests, fixed priority:
  - Stimulus: ic 0x100 and dc 0x200 pulse in the same cycle.
  - Response: first mem_raddr=0x200 (DC), then 0x100 after DC's rvalid plus one IDLE cycle; each rvalid goes only to its owner.
- Same stimulus with ARB_RR_EN:
  - Response: first grant 0x100 (IC). Repeat the tie: the second grant goes to DC.
- mem_rrdy held 0 for 5 cycles with ic pending:
  - Response: mem_ren stays 0 and ic_rrdy stays 0; mem_ren issues in the cycle after mem_rrdy rises.
- Protocol violation:
  - Stimulus: dc_ren pulsed while dc_rrdy=0.
  - Response: ignored, no extra memory read.
- Reset during WAIT, then mem_rvalid=1:
  - Response: ic_rvalid=dc_rvalid=0, mem_ren=0, both rrdy=1.
